// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory reinit/verify controller.
package mem_ctrl_pkg;

    localparam int ERR_CNT_W = 16;
    localparam int ADDR_W    = 32;

    // Controller modes: user access, golden-to-working copy, compare sweep.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COPY   = 2'd1,
        VERIFY = 2'd2
    } ctrl_state_t;

    // Verify result registers kept together so they clear and hold as one unit.
    typedef struct packed {
        logic                 valid;
        logic [ERR_CNT_W-1:0] cnt;
        logic [ADDR_W-1:0]    first_addr;
    } err_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/addr_sweeper.sv
// Address generator shared by the copy and verify sweeps. It issues
// addresses 0..DEPTH-1 one per cycle and keeps a one-cycle-delayed copy that
// lines up with the registered read data of both RAMs.
module addr_sweeper
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH = 8192,
    parameter int CNT_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    output logic              o_addr_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last,
    output logic              o_dly_valid,
    output logic [ADDR_W-1:0] o_dly_addr
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    logic             r_active;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dly_valid;
    logic [CNT_W-1:0] r_dly_cnt;
    logic             r_dly_last;
    logic             w_issue_last;

    assign w_issue_last = r_active && (r_cnt == LAST_CNT);

    // Issue counter: starts at 0 after i_start, stops after the last address.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
        end else if (r_active) begin
            if (w_issue_last) begin
                r_active <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Delay stage aligned with the 1-cycle registered RAM reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dly_valid <= 1'b0;
            r_dly_cnt   <= '0;
            r_dly_last  <= 1'b0;
        end else begin
            r_dly_valid <= r_active;
            r_dly_cnt   <= r_cnt;
            r_dly_last  <= w_issue_last;
        end
    end

    assign o_addr_valid = r_active;
    assign o_addr       = {{(ADDR_W - CNT_W){1'b0}}, r_cnt};
    assign o_dly_valid  = r_dly_valid;
    assign o_dly_addr   = {{(ADDR_W - CNT_W){1'b0}}, r_dly_cnt};
    // Delayed stage holds the final address: last write/compare of the sweep.
    assign o_last       = r_dly_valid && r_dly_last;

endmodule

// File: rtl/mem_reinit_ctrl.sv
// Arbitrates the working RAM between the user port and two background
// sweeps: COPY rewrites it from the golden image, VERIFY compares the two
// and records mismatches.
module mem_reinit_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int WID_MEM   = 4,
    parameter int DEPTH_MEM = 8192
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_reinit,
    input  logic                 start_verify,
    output logic                 busy,
    output logic                 done,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [ADDR_W-1:0]    err_first_addr,
    output logic                 err_valid,
    output logic                 usr_ready,
    input  logic                 usr_wen,
    input  logic [ADDR_W-1:0]    usr_waddr,
    input  logic [WID_MEM-1:0]   usr_din,
    input  logic                 usr_ren,
    input  logic [ADDR_W-1:0]    usr_raddr,
    output logic                 usr_rvalid,
    output logic [WID_MEM-1:0]   usr_dout,
    output logic                 mem_we,
    output logic [ADDR_W-1:0]    mem_waddr,
    output logic [WID_MEM-1:0]   mem_din,
    output logic [ADDR_W-1:0]    mem_raddr,
    input  logic [WID_MEM-1:0]   mem_dout,
    output logic [ADDR_W-1:0]    gold_raddr,
    input  logic [WID_MEM-1:0]   gold_dout
);

    ctrl_state_t       r_state;
    ctrl_state_t       w_next_state;
    err_state_t        r_err;
    logic              r_usr_rvalid;

    logic              w_sweep_start;
    logic              w_verify_start;
    logic              w_sweep_done;
    logic              w_mismatch;
    logic              w_addr_valid;
    logic [ADDR_W-1:0] w_addr;
    logic              w_last;
    logic              w_dly_valid;
    logic [ADDR_W-1:0] w_dly_addr;

    addr_sweeper #(
        .DEPTH (DEPTH_MEM)
    ) u_sweeper (
        .clk          (clk),
        .reset        (reset),
        .i_start      (w_sweep_start),
        .o_addr_valid (w_addr_valid),
        .o_addr       (w_addr),
        .o_last       (w_last),
        .o_dly_valid  (w_dly_valid),
        .o_dly_addr   (w_dly_addr)
    );

    // The sweep ends on the cycle of its last write or compare.
    assign w_sweep_done = (r_state != IDLE) && w_last;

    // Compare registered RAM outputs while the delayed verify stage is live.
    assign w_mismatch = (r_state == VERIFY) && w_dly_valid && (mem_dout != gold_dout);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state, port arbitration and sweep control.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        w_next_state   = r_state;
        w_sweep_start  = 1'b0;
        w_verify_start = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        usr_ready      = 1'b0;
        mem_we         = 1'b0;
        mem_waddr      = '0;
        mem_din        = '0;
        mem_raddr      = '0;
        gold_raddr     = '0;

        case (r_state)
            IDLE: begin
                usr_ready = 1'b1;
                if (usr_wen) begin
                    mem_we    = 1'b1;
                    mem_waddr = usr_waddr;
                    mem_din   = usr_din;
                end
                if (usr_ren) begin
                    mem_raddr = usr_raddr;
                end
                // Reinit has priority when both requests arrive together.
                if (start_reinit) begin
                    w_next_state  = COPY;
                    w_sweep_start = 1'b1;
                end else if (start_verify) begin
                    w_next_state   = VERIFY;
                    w_sweep_start  = 1'b1;
                    w_verify_start = 1'b1;
                end
            end

            COPY: begin
                busy = 1'b1;
                done = w_sweep_done;
                if (w_addr_valid) begin
                    gold_raddr = w_addr;
                end
                if (w_dly_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = w_dly_addr;
                    mem_din   = gold_dout;
                end
                if (w_sweep_done) begin
                    w_next_state = IDLE;
                end
            end

            VERIFY: begin
                busy = 1'b1;
                done = w_sweep_done;
                if (w_addr_valid) begin
                    mem_raddr  = w_addr;
                    gold_raddr = w_addr;
                end
                if (w_sweep_done) begin
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Verify results: cleared on entry, accumulated per compare, held afterwards.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_err <= '0;
        end else if (w_verify_start) begin
            r_err <= '0;
        end else if (w_mismatch) begin
            r_err.cnt <= sat_inc(r_err.cnt);
            if (!r_err.valid) begin
                r_err.valid      <= 1'b1;
                r_err.first_addr <= w_dly_addr;
            end
        end
    end

    // Read data returns one cycle after an accepted user read.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_usr_rvalid <= 1'b0;
        end else begin
            r_usr_rvalid <= (r_state == IDLE) && usr_ren;
        end
    end

    assign usr_rvalid     = r_usr_rvalid;
    assign usr_dout       = mem_dout;
    assign err_cnt        = r_err.cnt;
    assign err_first_addr = r_err.first_addr;
    assign err_valid      = r_err.valid;

endmodule

// File: tb/tb_mem_reinit_ctrl.sv
// Self-checking bench for mem_reinit_ctrl with behavioural working/golden RAMs.
module tb_mem_reinit_ctrl;

    localparam int WID       = 4;
    localparam int DEPTH     = 16;
    localparam int BIG_DEPTH = 70000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            start_reinit;
    logic            start_verify;
    logic            busy;
    logic            done;
    logic [15:0]     err_cnt;
    logic [31:0]     err_first_addr;
    logic            err_valid;
    logic            usr_ready;
    logic            usr_wen;
    logic [31:0]     usr_waddr;
    logic [WID-1:0]  usr_din;
    logic            usr_ren;
    logic [31:0]     usr_raddr;
    logic            usr_rvalid;
    logic [WID-1:0]  usr_dout;
    logic            mem_we;
    logic [31:0]     mem_waddr;
    logic [WID-1:0]  mem_din;
    logic [31:0]     mem_raddr;
    logic [WID-1:0]  mem_dout;
    logic [31:0]     gold_raddr;
    logic [WID-1:0]  gold_dout;

    // Second instance for the saturation sweep (always mismatching data).
    logic            b_start_verify;
    logic            b_busy;
    logic            b_done;
    logic [15:0]     b_err_cnt;
    logic [31:0]     b_err_first_addr;
    logic            b_err_valid;
    logic            b_usr_ready;
    logic            b_usr_rvalid;
    logic [WID-1:0]  b_usr_dout;
    logic            b_mem_we;
    logic [31:0]     b_mem_waddr;
    logic [WID-1:0]  b_mem_din;
    logic [31:0]     b_mem_raddr;
    logic [31:0]     b_gold_raddr;

    int checks = 0;
    int errors = 0;

    // Environment RAMs: 1-cycle registered read, read-before-write.
    logic [WID-1:0] wram [DEPTH];
    logic [WID-1:0] gram [DEPTH];

    // Reference model state.
    logic [WID-1:0] model [DEPTH];
    int             m_err_cnt;
    logic           m_err_valid;
    int             m_err_first;

    mem_reinit_ctrl #(.WID_MEM(WID), .DEPTH_MEM(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .start_reinit(start_reinit), .start_verify(start_verify),
        .busy(busy), .done(done),
        .err_cnt(err_cnt), .err_first_addr(err_first_addr), .err_valid(err_valid),
        .usr_ready(usr_ready),
        .usr_wen(usr_wen), .usr_waddr(usr_waddr), .usr_din(usr_din),
        .usr_ren(usr_ren), .usr_raddr(usr_raddr),
        .usr_rvalid(usr_rvalid), .usr_dout(usr_dout),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_din(mem_din), .mem_raddr(mem_raddr),
        .mem_dout(mem_dout),
        .gold_raddr(gold_raddr), .gold_dout(gold_dout)
    );

    mem_reinit_ctrl #(.WID_MEM(WID), .DEPTH_MEM(BIG_DEPTH)) dut_sat (
        .clk(clk), .reset(reset),
        .start_reinit(1'b0), .start_verify(b_start_verify),
        .busy(b_busy), .done(b_done),
        .err_cnt(b_err_cnt), .err_first_addr(b_err_first_addr), .err_valid(b_err_valid),
        .usr_ready(b_usr_ready),
        .usr_wen(1'b0), .usr_waddr(32'd0), .usr_din(4'h0),
        .usr_ren(1'b0), .usr_raddr(32'd0),
        .usr_rvalid(b_usr_rvalid), .usr_dout(b_usr_dout),
        .mem_we(b_mem_we), .mem_waddr(b_mem_waddr), .mem_din(b_mem_din), .mem_raddr(b_mem_raddr),
        .mem_dout(4'h1),
        .gold_raddr(b_gold_raddr), .gold_dout(4'h0)
    );

    always @(posedge clk) begin
        if (mem_we) wram[mem_waddr[3:0]] <= mem_din;
        mem_dout  <= wram[mem_raddr[3:0]];
        gold_dout <= gram[gold_raddr[3:0]];
    end

    function automatic logic [WID-1:0] gold_of(input int k);
        return WID'(k);
    endfunction

    // Expected verify outcome from the model contents.
    task automatic model_verify();
        m_err_cnt   = 0;
        m_err_valid = 1'b0;
        m_err_first = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (model[k] != gold_of(k)) begin
                if (!m_err_valid) begin
                    m_err_valid = 1'b1;
                    m_err_first = k;
                end
                if (m_err_cnt < 65535) m_err_cnt++;
            end
        end
    endtask

    task automatic idle_inputs();
        start_reinit = 1'b0;
        start_verify = 1'b0;
        usr_wen      = 1'b0;
        usr_waddr    = 32'd0;
        usr_din      = '0;
        usr_ren      = 1'b0;
        usr_raddr    = 32'd0;
    endtask

    task automatic check_err_regs(input string tag);
        checks++;
        if (err_cnt !== 16'(m_err_cnt) || err_valid !== m_err_valid ||
            (m_err_valid && err_first_addr !== 32'(m_err_first))) begin
            errors++;
            $display("FAIL %s_err: cnt=%0d valid=%0b first=%0d want cnt=%0d valid=%0b first=%0d",
                     tag, err_cnt, err_valid, err_first_addr, m_err_cnt, m_err_valid, m_err_first);
        end
    endtask

    // Back-to-back user reads of every address, compared with the model.
    task automatic read_all(input string tag);
        for (int i = 0; i <= DEPTH; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            if (i < DEPTH) begin
                usr_ren   = 1'b1;
                usr_raddr = 32'(i);
            end
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (usr_rvalid !== 1'b1 || usr_dout !== model[i-1]) begin
                    errors++;
                    $display("FAIL %s_read[%0d]: rvalid=%0b data=%h want rvalid=1 data=%h",
                             tag, i - 1, usr_rvalid, usr_dout, model[i-1]);
                end
            end
        end
    endtask

    task automatic user_write(input int addr, input logic [WID-1:0] data);
        @(posedge clk); #1;
        idle_inputs();
        usr_wen   = 1'b1;
        usr_waddr = 32'(addr);
        usr_din   = data;
        @(negedge clk);
        checks++;
        if (usr_ready !== 1'b1 || mem_we !== 1'b1 || mem_waddr !== 32'(addr) || mem_din !== data) begin
            errors++;
            $display("FAIL user_write[%0d]: ready=%0b we=%0b waddr=%0d din=%h want 1 1 %0d %h",
                     addr, usr_ready, mem_we, mem_waddr, mem_din, addr, data);
        end
        model[addr] = data;
    endtask

    // One full sweep. st_op adds a user read+write in the start cycle; poke
    // re-requests both starts mid-sweep; junk drives user traffic while busy.
    task automatic run_sweep(input logic sr, input logic sv, input int poke, input bit junk,
                             input bit st_op, input int st_addr, input logic [WID-1:0] st_data,
                             input string tag);
        int             n_done;
        logic [WID-1:0] pend;
        logic           copy_mode;
        logic           exp_rv;
        n_done    = 0;
        pend      = '0;
        copy_mode = sr;

        @(posedge clk); #1;
        idle_inputs();
        start_reinit = sr;
        start_verify = sv;
        if (st_op) begin
            usr_ren   = 1'b1;
            usr_raddr = 32'(st_addr);
            usr_wen   = 1'b1;
            usr_waddr = 32'(st_addr);
            usr_din   = st_data;
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || usr_ready !== 1'b1 || usr_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL %s_c0: busy=%0b ready=%0b rvalid=%0b want 0 1 0", tag, busy, usr_ready, usr_rvalid);
        end
        if (st_op) begin
            pend           = model[st_addr];
            model[st_addr] = st_data;
        end

        for (int c = 1; c <= DEPTH + 1; c++) begin
            @(posedge clk); #1;
            idle_inputs();
            if (c == poke) begin
                start_reinit = 1'b1;
                start_verify = 1'b1;
            end
            if (junk) begin
                usr_wen   = 1'b1;
                usr_waddr = $urandom_range(0, DEPTH - 1);
                usr_din   = WID'($urandom);
                usr_ren   = 1'b1;
                usr_raddr = $urandom_range(0, DEPTH - 1);
            end
            @(negedge clk);
            if (done === 1'b1) n_done++;
            exp_rv = (c == 1) && st_op;
            checks++;
            if (busy !== 1'b1 || usr_ready !== 1'b0 || done !== (c == DEPTH + 1)) begin
                errors++;
                $display("FAIL %s_c%0d_ctrl: busy=%0b ready=%0b done=%0b want 1 0 %0b",
                         tag, c, busy, usr_ready, done, (c == DEPTH + 1));
            end
            checks++;
            if (usr_rvalid !== exp_rv || (exp_rv && usr_dout !== pend)) begin
                errors++;
                $display("FAIL %s_c%0d_rvalid: rvalid=%0b data=%h want %0b %h", tag, c, usr_rvalid, usr_dout, exp_rv, pend);
            end
            if (c <= DEPTH) begin
                checks++;
                if (gold_raddr !== 32'(c - 1) || (!copy_mode && mem_raddr !== 32'(c - 1))) begin
                    errors++;
                    $display("FAIL %s_c%0d_issue: gold_raddr=%0d mem_raddr=%0d want %0d", tag, c, gold_raddr, mem_raddr, c - 1);
                end
            end
            checks++;
            if (copy_mode) begin
                if (mem_we !== (c >= 2) || (c >= 2 && (mem_waddr !== 32'(c - 2) || mem_din !== gold_of(c - 2)))) begin
                    errors++;
                    $display("FAIL %s_c%0d_write: we=%0b waddr=%0d din=%h want %0b %0d %h",
                             tag, c, mem_we, mem_waddr, mem_din, (c >= 2), c - 2, gold_of(c - 2));
                end
            end else if (mem_we !== 1'b0) begin
                errors++;
                $display("FAIL %s_c%0d_we: we=%0b want 0", tag, c, mem_we);
            end
        end

        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || usr_ready !== 1'b1 || done !== 1'b0 || usr_rvalid !== 1'b0 || n_done != 1) begin
            errors++;
            $display("FAIL %s_end: busy=%0b ready=%0b done=%0b rvalid=%0b pulses=%0d want 0 1 0 0 1",
                     tag, busy, usr_ready, done, usr_rvalid, n_done);
        end
        if (copy_mode) begin
            for (int k = 0; k < DEPTH; k++) model[k] = gold_of(k);
        end else begin
            model_verify();
        end
        check_err_regs(tag);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || usr_rvalid !== 1'b0 || mem_we !== 1'b0 || usr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%0b done=%0b rvalid=%0b we=%0b ready=%0b want 0 0 0 0 1",
                     busy, done, usr_rvalid, mem_we, usr_ready);
        end
        checks++;
        if (err_cnt !== 16'd0 || err_valid !== 1'b0 || err_first_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_err: cnt=%0d valid=%0b first=%0d want 0 0 0", err_cnt, err_valid, err_first_addr);
        end
        checks++;
        if (mem_waddr !== 32'd0 || mem_raddr !== 32'd0 || gold_raddr !== 32'd0) begin
            errors++;
            $display("FAIL reset_addr: waddr=%0d raddr=%0d graddr=%0d want 0 0 0", mem_waddr, mem_raddr, gold_raddr);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        m_err_cnt   = 0;
        m_err_valid = 1'b0;
        m_err_first = 0;
    endtask

    task automatic test_reinit();
        run_sweep(1'b1, 1'b0, 0, 1'b0, 1'b0, 0, '0, "reinit");
        read_all("reinit");
    endtask

    task automatic test_verify();
        run_sweep(1'b0, 1'b1, 0, 1'b0, 1'b0, 0, '0, "verify_clean");
        user_write(5, 4'hA);
        run_sweep(1'b0, 1'b1, 0, 1'b0, 1'b1, 9, 4'hA, "verify_err");
        checks++;
        if (err_cnt !== 16'd2 || err_first_addr !== 32'd5 || err_valid !== 1'b1) begin
            errors++;
            $display("FAIL verify_err_fixed: cnt=%0d first=%0d valid=%0b want 2 5 1", err_cnt, err_first_addr, err_valid);
        end
    endtask

    task automatic test_user_random();
        logic           pend_v;
        logic [WID-1:0] pend_d;
        pend_v = 1'b0;
        pend_d = '0;
        for (int i = 0; i <= 60; i++) begin
            @(posedge clk); #1;
            idle_inputs();
            if (i < 60) begin
                usr_ren   = 1'($urandom_range(0, 1));
                usr_raddr = $urandom_range(0, DEPTH - 1);
                usr_wen   = 1'($urandom_range(0, 1));
                usr_waddr = (i % 3 == 0) ? usr_raddr : $urandom_range(0, DEPTH - 1);
                usr_din   = WID'($urandom);
            end
            @(negedge clk);
            checks++;
            if (usr_ready !== 1'b1 || mem_we !== usr_wen || usr_rvalid !== pend_v || (pend_v && usr_dout !== pend_d)) begin
                errors++;
                $display("FAIL user_random[%0d]: ready=%0b we=%0b rvalid=%0b data=%h want 1 %0b %0b %h",
                         i, usr_ready, mem_we, usr_rvalid, usr_dout, usr_wen, pend_v, pend_d);
            end
            pend_v = usr_ren;
            if (usr_ren) pend_d = model[usr_raddr[3:0]];
            if (usr_wen) model[usr_waddr[3:0]] = usr_din;
        end
        run_sweep(1'b0, 1'b1, 0, 1'b0, 1'b0, 0, '0, "verify_random");
    endtask

    task automatic test_back_to_back();
        run_sweep(1'b1, 1'b1, 6, 1'b0, 1'b0, 0, '0, "both_starts");
        run_sweep(1'b0, 1'b1, 9, 1'b0, 1'b0, 0, '0, "verify_after_copy");
    endtask

    task automatic test_user_during_sweep();
        run_sweep(1'b0, 1'b1, 0, 1'b1, 1'b0, 0, '0, "junk_verify");
        read_all("junk_verify");
        run_sweep(1'b1, 1'b0, 0, 1'b1, 1'b0, 0, '0, "junk_copy");
        read_all("junk_copy");
    endtask

    task automatic test_reset_mid_copy();
        for (int k = 0; k < DEPTH; k++) begin
            user_write(k, gold_of(k) ^ WID'($urandom_range(1, 15)));
        end
        run_sweep(1'b0, 1'b1, 0, 1'b0, 1'b0, 0, '0, "pre_reset_verify");
        @(posedge clk); #1;
        idle_inputs();
        start_reinit = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            idle_inputs();
            reset = (c == 8);
            @(negedge clk);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_we !== 1'b0 || usr_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_ctrl: busy=%0b we=%0b ready=%0b done=%0b want 0 0 1 0", busy, mem_we, usr_ready, done);
        end
        for (int k = 0; k <= 6; k++) model[k] = gold_of(k);
        m_err_cnt   = 0;
        m_err_valid = 1'b0;
        m_err_first = 0;
        check_err_regs("midreset");
        read_all("midreset");
    endtask

    task automatic test_saturation();
        bit   found;
        int   done_cyc;
        logic saw_we;
        found    = 1'b0;
        done_cyc = 0;
        saw_we   = 1'b0;
        @(posedge clk); #1;
        b_start_verify = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= BIG_DEPTH + 5 && !found; c++) begin
            @(posedge clk); #1;
            b_start_verify = 1'b0;
            @(negedge clk);
            if (b_mem_we !== 1'b0) saw_we = 1'b1;
            if (b_done === 1'b1) begin
                found    = 1'b1;
                done_cyc = c;
            end
        end
        checks++;
        if (!found || done_cyc != BIG_DEPTH + 1 || saw_we) begin
            errors++;
            $display("FAIL sat_done: found=%0b cycle=%0d wrote=%0b want 1 %0d 0", found, done_cyc, saw_we, BIG_DEPTH + 1);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (b_err_cnt !== 16'hFFFF || b_err_valid !== 1'b1 || b_err_first_addr !== 32'd0 ||
            b_busy !== 1'b0 || b_usr_ready !== 1'b1) begin
            errors++;
            $display("FAIL sat_err: cnt=%h valid=%0b first=%0d busy=%0b ready=%0b want ffff 1 0 0 1",
                     b_err_cnt, b_err_valid, b_err_first_addr, b_busy, b_usr_ready);
        end
    endtask

    initial begin
        idle_inputs();
        reset          = 1'b1;
        b_start_verify = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            gram[k]  = gold_of(k);
            wram[k] <= 4'hF;
            model[k] = 4'hF;
        end
        test_reset();
        test_reinit();
        test_verify();
        test_user_random();
        test_back_to_back();
        test_user_during_sweep();
        test_reset_mid_copy();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
